// File: rtl/o_buft_ds_lane_arbiter.sv
// Round-robin arbiter and LSB-first serializer for a shared O_BUFT_DS lane.
// Two requesters hand over a word plus bit count. The winner's word is shifted
// out with buf_t high. The lane is then held hi-Z for TURN_CYC cycles before
// the next grant. All outputs are registered.
module o_buft_ds_lane_arbiter #(
  parameter int unsigned MAX_BITS = 16,
  parameter int unsigned LEN_W    = 5,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [MAX_BITS-1:0] data0,
  input  logic [MAX_BITS-1:0] data1,
  input  logic [LEN_W-1:0]    len0,
  input  logic [LEN_W-1:0]    len1,
  input  logic                abort,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                aborted,
  output logic                busy,
  output logic                buf_i,
  output logic                buf_t
);

  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_BITS);
  localparam logic [3:0]       TurnLast = 4'(TURN_CYC - 1);

  typedef enum logic [1:0] {StIdle, StShift, StTurn} state_e;

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          tcnt_q, tcnt_d;
  logic                last_owner_q, last_owner_d;
  logic                owner_q, owner_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, busy_d;
  logic                buf_i_q, buf_i_d;
  logic                buf_t_q, buf_t_d;

  logic                win;
  logic [MAX_BITS-1:0] win_data;
  logic [LEN_W-1:0]    win_len, eff_len;

  // Pick the winner (tie goes to the requester that did not own the lane last)
  // and clamp its length to 1..MAX_BITS.
  always_comb begin
    win      = (req == 2'b11) ? ~last_owner_q : req[1];
    win_data = win ? data1 : data0;
    win_len  = win ? len1 : len0;
    eff_len  = win_len;
    if (win_len == '0) begin
      eff_len = LEN_W'(1);
    end else if (win_len > MaxLen) begin
      eff_len = MaxLen;
    end
  end

  // Next-state and registered-output logic; cnt_q holds bits still to drive
  // after the one currently on buf_i.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    aborted_d    = 1'b0;
    busy_d       = busy_q;
    buf_i_d      = 1'b0;
    buf_t_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          state_d      = StShift;
          owner_d      = win;
          last_owner_d = win;
          gnt_d        = win ? 2'b10 : 2'b01;
          buf_t_d      = 1'b1;
          buf_i_d      = win_data[0];
          shreg_d      = win_data >> 1;
          cnt_d        = eff_len - 1'b1;
          busy_d       = 1'b1;
        end
      end
      StShift: begin
        if (abort || (cnt_q == '0)) begin
          state_d   = StTurn;
          done_d    = owner_q ? 2'b10 : 2'b01;
          aborted_d = abort;
          tcnt_d    = TurnLast;
        end else begin
          buf_t_d = 1'b1;
          buf_i_d = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      StTurn: begin
        if (tcnt_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset releases the pads (buf_t low) without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      buf_i_q      <= 1'b0;
      buf_t_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      buf_i_q      <= buf_i_d;
      buf_t_q      <= buf_t_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign busy    = busy_q;
  assign buf_i   = buf_i_q;
  assign buf_t   = buf_t_q;

endmodule

// File: tb/tb_o_buft_ds_lane_arbiter.sv
// Scoreboard bench: stimulus pushes expected gnt / bit / done events, a negedge
// monitor pops and compares them; stimulus also checks cycle-exact timing.
module tb_o_buft_ds_lane_arbiter;

  localparam int TURN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] data0 = '0, data1 = '0;
  logic [4:0]  len0 = '0, len1 = '0;
  logic        abort = 1'b0;
  logic [1:0]  gnt, done;
  logic        aborted, busy, buf_i, buf_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] exp_gnt[$];
  logic       exp_bit[$];
  logic [2:0] exp_done[$];  // {aborted, done}

  o_buft_ds_lane_arbiter #(.MAX_BITS(16), .LEN_W(5), .TURN_CYC(TURN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .len0(len0), .len1(len1), .abort(abort), .gnt(gnt), .done(done),
    .aborted(aborted), .busy(busy), .buf_i(buf_i), .buf_t(buf_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented gnt, driven bit and done against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 2'b00) begin
        if (exp_gnt.size() == 0) check("spurious_gnt", {30'd0, gnt}, 32'd0);
        else check("gnt", {30'd0, gnt}, {30'd0, exp_gnt.pop_front()});
      end
      if (buf_t) begin
        if (exp_bit.size() == 0) check("spurious_bit", 32'd1, 32'd0);
        else check("bit", {31'd0, buf_i}, {31'd0, exp_bit.pop_front()});
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) check("spurious_done", {30'd0, done}, 32'd0);
        else check("done", {29'd0, aborted, done}, {29'd0, exp_done.pop_front()});
      end
    end
  end

  // One transfer by requester k (tie: both request). Checks timing from gnt to IDLE.
  task automatic run_single(input int k, input bit tie, input logic [15:0] d,
                            input logic [4:0] l, input int nbits);
    logic [1:0] oh;
    oh = (k == 1) ? 2'b10 : 2'b01;
    if (k == 1) begin data1 = d; data0 = ~d; end
    else begin data0 = d; data1 = ~d; end
    len0 = l;
    len1 = l;
    exp_gnt.push_back(oh);
    for (int i = 0; i < nbits; i++) exp_bit.push_back(d[i]);
    exp_done.push_back({1'b0, oh});
    req = tie ? 2'b11 : oh;
    step();  // N+1
    req = 2'b00;
    check("gnt_time", {30'd0, gnt}, {30'd0, oh});
    check("busy_shift", {31'd0, busy}, 32'd1);
    check("buf_t_shift", {31'd0, buf_t}, 32'd1);
    repeat (nbits) step();  // N+L+1
    check("done_time", {30'd0, done}, {30'd0, oh});
    check("buf_t_turn", {31'd0, buf_t}, 32'd0);
    check("busy_turn", {31'd0, busy}, 32'd1);
    repeat (TURN - 1) step();  // N+L+TURN
    check("busy_turn_end", {31'd0, busy}, 32'd1);
    step();  // N+L+TURN+1
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int last_g;
    bool_dummy: begin end
    // Reset values.
    #3;
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_buf_t", {31'd0, buf_t}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_aborted", {31'd0, aborted}, 32'd0);

    // Held tie: order 0,1,0,1, grants 7 cycles apart.
    data0 = 16'h0009;
    data1 = 16'h0006;
    len0 = 5'd4;
    len1 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] oh;
      logic [15:0] dv;
      oh = (i % 2 == 1) ? 2'b10 : 2'b01;
      dv = (i % 2 == 1) ? 16'h0006 : 16'h0009;
      exp_gnt.push_back(oh);
      for (int b = 0; b < 4; b++) exp_bit.push_back(dv[b]);
      exp_done.push_back({1'b0, oh});
    end
    req = 2'b11;
    last_g = 0;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (gnt == 2'b00 && n < 20);
      if (gnt == 2'b00) check("gnt_timeout", 32'd0, 32'd1);
      else if (i > 0) check("gnt_gap", cyc - last_g, 32'd7);
      last_g = cyc;
    end
    req = 2'b00;
    repeat (6) step();
    check("held_idle", {31'd0, busy}, 32'd0);

    // Single request from the test plan.
    run_single(0, 1'b0, 16'hA5C3, 5'd8, 8);
    // Length clamps.
    run_single(1, 1'b0, 16'h8001, 5'd0, 1);
    run_single(1, 1'b0, 16'h1234, 5'd31, 16);

    // Abort at the 5th SHIFT cycle.
    data0 = 16'h00F5;
    len0 = 5'd16;
    exp_gnt.push_back(2'b01);
    for (int i = 0; i < 5; i++) exp_bit.push_back(data0[i]);
    exp_done.push_back(3'b101);
    req = 2'b01;
    step();
    req = 2'b00;
    repeat (4) step();  // N+5
    abort = 1'b1;
    step();  // N+6
    abort = 1'b0;
    check("abort_buf_t", {31'd0, buf_t}, 32'd0);
    check("abort_done", {29'd0, aborted, done}, 32'h5);
    step();
    check("abort_turn2", {31'd0, busy}, 32'd1);
    step();
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Async reset mid-SHIFT, requester 0 owns the lane.
    data0 = 16'h0F0F;
    len0 = 5'd16;
    exp_gnt.push_back(2'b01);
    for (int i = 0; i < 3; i++) exp_bit.push_back(data0[i]);
    req = 2'b01;
    step();
    req = 2'b00;
    repeat (2) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_buf_t", {31'd0, buf_t}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_gnt", {30'd0, gnt}, 32'd0);
    check("arst_done", {30'd0, done}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_single(0, 1'b1, 16'h0002, 5'd2, 2);

    // Withdrawn request between edges: no grant, last_owner untouched.
    @(posedge clk);
    #2;
    req = 2'b10;
    #2;
    req = 2'b00;
    repeat (4) step();
    check("withdraw_busy", {31'd0, busy}, 32'd0);
    run_single(1, 1'b1, 16'h0001, 5'd2, 2);

    repeat (3) step();
    check("left_gnt", exp_gnt.size(), 32'd0);
    check("left_bit", exp_bit.size(), 32'd0);
    check("left_done", exp_done.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
